// File: rtl/lane_ser_pkg.sv
// Shared types, default sizing and the popcount helper for the lane mask serializer.
package lane_ser_pkg;

  localparam int LANE_SER_WIDTH = 8;
  localparam int LANE_SER_IDX_W = $clog2(LANE_SER_WIDTH);
  // Popcount operates on a fixed wide vector; callers zero-extend their mask.
  localparam int LANE_SER_MAX_W = 64;

  typedef enum logic [0:0] {ST_IDLE, ST_WALK} lane_ser_state_t;

  function automatic int unsigned lane_popcount(input logic [LANE_SER_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < LANE_SER_MAX_W; i++) n = n + {31'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/lane_ffs.sv
// Combinational first-set encoder: index of the lowest set bit, 0 when none.
module lane_ffs #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] mask,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan high to low so the lowest set bit is the final winner.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lane_mask_serializer.sv
// Walks an accepted lane mask and emits one set-lane index per handshake, lowest first.
// Define LANE_SER_B2B_EN to accept the next mask on the final index handshake (no idle bubble).
module lane_mask_serializer
  import lane_ser_pkg::*;
#(
  parameter int WIDTH = LANE_SER_WIDTH,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             I_Mask_Valid,
  input  logic [WIDTH-1:0] I_Mask,
  output logic             O_Mask_Ready,
  output logic             O_Idx_Valid,
  output logic [IDX_W-1:0] O_Idx,
  output logic             O_Last,
  input  logic             I_Idx_Ready,
  output logic [IDX_W:0]   O_Remain,
  output logic             O_Empty
);

  lane_ser_state_t  state;
  logic [WIDTH-1:0] r_mask;
  logic             r_empty;

  logic [IDX_W-1:0] ffs_idx;
  logic             ffs_found;
  logic [WIDTH-1:0] mask_clr;
  logic             last_raw;
  logic             walking;
  logic             mask_acc;
  logic             idx_hs;

  lane_ffs #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_ffs (
    .mask  (r_mask),
    .idx   (ffs_idx),
    .found (ffs_found)
  );

  // Clearing the lowest set bit is the same as clearing bit ffs_idx.
  assign mask_clr = r_mask & (r_mask - WIDTH'(1));
  assign last_raw = ffs_found && (mask_clr == '0);
  assign walking  = (state == ST_WALK);

  assign O_Idx_Valid = !reset && walking;
  assign O_Idx       = reset ? '0 : ffs_idx;
  assign O_Last      = !reset && last_raw;
  assign O_Remain    = (reset || !walking) ? '0
                     : (IDX_W+1)'(lane_popcount(LANE_SER_MAX_W'(r_mask)));
  assign O_Empty     = !reset && r_empty;

`ifdef LANE_SER_B2B_EN
  assign O_Mask_Ready = !reset && (walking ? (last_raw && I_Idx_Ready) : 1'b1);
`else
  assign O_Mask_Ready = !reset && !walking;
`endif

  assign mask_acc = I_Mask_Valid && O_Mask_Ready;
  assign idx_hs   = O_Idx_Valid && I_Idx_Ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      r_mask  <= '0;
      r_empty <= 1'b0;
    end else begin
      r_empty <= mask_acc && (I_Mask == '0);
      case (state)
        ST_IDLE: begin
          if (mask_acc && (I_Mask != '0)) begin
            r_mask <= I_Mask;
            state  <= ST_WALK;
          end
        end
        ST_WALK: begin
          if (idx_hs) begin
            // mask_acc can only fire here on the last index with back-to-back enabled
            if (mask_acc) begin
              r_mask <= I_Mask;
              state  <= (I_Mask != '0) ? ST_WALK : ST_IDLE;
            end else begin
              r_mask <= mask_clr;
              if (last_raw) state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
